// File: rtl/monitor_pkg.sv
// Shared definitions for the bus-monitor snapshot reader: frame geometry,
// field slice offsets, FSM state encoding and field extraction helpers.
package monitor_pkg;

  // Frame geometry
  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 16;
  localparam int SIG_W   = 8;
  localparam int FRAME_W = ADDR_W + DATA_W + SIG_W;

  // Field slice offsets inside the 48-bit frame (frame bit 47 arrives first)
  localparam int SIG_LSB  = 0;
  localparam int DATA_LSB = SIG_LSB + SIG_W;
  localparam int ADDR_LSB = DATA_LSB + DATA_W;

  // Number of SCK rises (and samples) per frame
  localparam logic [5:0] EDGE_LAST = 6'd48;

  // FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SYNC   = 3'd1;
  localparam state_t ST_SETUP  = 3'd2;
  localparam state_t ST_SCK_HI = 3'd3;
  localparam state_t ST_SCK_LO = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  // Field extraction from an assembled frame
  function automatic logic [ADDR_W-1:0] frame_addr(input logic [FRAME_W-1:0] frame);
    return frame[ADDR_LSB +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] frame_data(input logic [FRAME_W-1:0] frame);
    return frame[DATA_LSB +: DATA_W];
  endfunction

  function automatic logic [SIG_W-1:0] frame_sig(input logic [FRAME_W-1:0] frame);
    return frame[SIG_LSB +: SIG_W];
  endfunction

endpackage

// File: rtl/spi_half_timer.sv
// SPI half-period timer: a CLK_DIV down-counter. LOAD_IN restarts the
// period; TC_OUT is high on the last system cycle of the period, so a state
// entered with LOAD_IN lasts exactly CLK_DIV cycles when left on TC_OUT.
module spi_half_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK_IN,
  input  logic RESET_IN,
  input  logic LOAD_IN,
  output logic TC_OUT
);

  localparam logic [7:0] LOAD_VAL = 8'(CLK_DIV - 1);

  logic [7:0] count_reg;

  // Reload on state entry, otherwise count down and hold at zero
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      count_reg <= 8'd0;
    end else if (LOAD_IN) begin
      count_reg <= LOAD_VAL;
    end else if (count_reg != 8'd0) begin
      count_reg <= count_reg - 8'd1;
    end
  end

  assign TC_OUT = (count_reg == 8'd0);

endmodule

// File: rtl/monitor_reader.sv
// Host-side SPI initiator that reads one 48-bit bus-monitor snapshot frame
// (MSB first) per request and presents it as address/data/signal fields
// with a one-cycle valid strobe.
//
// Build option: define MONITOR_READER_SYNC_EN to pass SPISI_IN through a
// two-flop synchronizer before sampling (requires CLK_DIV >= 3). Without it
// SPISI_IN is sampled directly (CLK_DIV >= 2).
module monitor_reader
  import monitor_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              CLK_IN,
  input  logic              RESET_IN,
  input  logic              START_IN,
  input  logic              SPISI_IN,
  output logic              SPICLK_OUT,
  output logic              SPISS_OUT,
  output logic [ADDR_W-1:0] ADDR_OUT,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic [SIG_W-1:0]  SIGNAL_OUT,
  output logic              VALID_OUT,
  output logic              BUSY_OUT
);

  state_t               state_reg;
  state_t               state_next;
  logic                 timer_load;
  logic                 timer_tc;
  logic [5:0]           edge_cnt_reg;
  logic [FRAME_W-1:0]   shift_reg;
  logic [FRAME_W-1:0]   frame_next;
  logic                 sample_en;
  logic                 sdi_bit;

  logic                 sck_reg;
  logic                 ss_reg;
  logic                 valid_reg;
  logic                 busy_reg;
  logic [ADDR_W-1:0]    addr_reg;
  logic [DATA_W-1:0]    data_reg;
  logic [SIG_W-1:0]     sig_reg;

`ifdef MONITOR_READER_SYNC_EN
  logic sync1_reg;
  logic sync2_reg;

  // Two-flop synchronizer on the serial input; the sample point does not
  // move, so the captured bit is the pin value two cycles earlier
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= SPISI_IN;
      sync2_reg <= sync1_reg;
    end
  end

  assign sdi_bit = sync2_reg;
`else
  assign sdi_bit = SPISI_IN;
`endif

  // Every state lasts CLK_DIV cycles except IDLE (waits for START) and DONE
  spi_half_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .CLK_IN   (CLK_IN),
    .RESET_IN (RESET_IN),
    .LOAD_IN  (timer_load),
    .TC_OUT   (timer_tc)
  );

  // Each state change restarts the half-period timer
  assign timer_load = (state_next != state_reg);

  // The sample is taken on the last cycle of each SCK low phase
  assign sample_en  = (state_reg == ST_SCK_LO) && timer_tc;

  // Shift register contents including the bit being sampled this cycle;
  // the fields load from this on the 48th sample so they appear with VALID
  assign frame_next = {shift_reg[FRAME_W-2:0], sdi_bit};

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (START_IN) begin
          state_next = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (timer_tc) begin
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (timer_tc) begin
          state_next = ST_SCK_HI;
        end
      end
      ST_SCK_HI: begin
        if (timer_tc) begin
          state_next = ST_SCK_LO;
        end
      end
      ST_SCK_LO: begin
        if (timer_tc) begin
          state_next = (edge_cnt_reg == EDGE_LAST) ? ST_DONE : ST_SCK_HI;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // SCK rise counter: cleared while idle, bumped on each entry to SCK_HI
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      edge_cnt_reg <= 6'd0;
    end else if (state_reg == ST_IDLE) begin
      edge_cnt_reg <= 6'd0;
    end else if ((state_next == ST_SCK_HI) && (state_reg != ST_SCK_HI)) begin
      edge_cnt_reg <= edge_cnt_reg + 6'd1;
    end
  end

  // Serial capture, left shift with the new bit entering at the LSB
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      shift_reg <= '0;
    end else if (sample_en) begin
      shift_reg <= frame_next;
    end
  end

  // Pin outputs registered from the next state so they align with it
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      sck_reg   <= 1'b0;
      ss_reg    <= 1'b0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      sck_reg   <= (state_next == ST_SCK_HI);
      ss_reg    <= (state_next == ST_SETUP) || (state_next == ST_SCK_HI) ||
                   (state_next == ST_SCK_LO);
      valid_reg <= (state_next == ST_DONE);
      busy_reg  <= (state_next != ST_IDLE);
    end
  end

  // Output fields update only when a frame completes and hold otherwise
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      addr_reg <= '0;
      data_reg <= '0;
      sig_reg  <= '0;
    end else if (state_next == ST_DONE) begin
      addr_reg <= frame_addr(frame_next);
      data_reg <= frame_data(frame_next);
      sig_reg  <= frame_sig(frame_next);
    end
  end

  assign SPICLK_OUT = sck_reg;
  assign SPISS_OUT  = ss_reg;
  assign VALID_OUT  = valid_reg;
  assign BUSY_OUT   = busy_reg;
  assign ADDR_OUT   = addr_reg;
  assign DATA_OUT   = data_reg;
  assign SIGNAL_OUT = sig_reg;

endmodule
